// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy packer slice.
//   TRNG_WORD_W         : packed word width expected by the whitener
//   TRNG_RCT_CUTOFF_DEF : default repetition-count cutoff
//   TRNG_RCT_CNT_W      : width of the repetition run counter
//   vn_state_t          : von Neumann debiaser pair phase
package trng_pkg;

   localparam int unsigned TRNG_WORD_W         = 32;
   localparam int unsigned TRNG_RCT_CUTOFF_DEF = 40;
   localparam int unsigned TRNG_RCT_CNT_W      = 8;

   typedef enum logic {
      VN_FIRST  = 1'b0,
      VN_SECOND = 1'b1
   } vn_state_t;

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test on accepted raw samples.
//   clk, rst     : clock, synchronous active-high reset
//   sample       : raw sample value
//   sample_valid : sample is accepted this cycle
//   clr          : single-cycle clear of fail and the run counter
//   fail         : sticky failure flag
module trng_rct_monitor
   import trng_pkg::*;
#(
   parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sample,
   input  logic sample_valid,
   input  logic clr,
   output logic fail
);

   localparam logic [TRNG_RCT_CNT_W-1:0] CUTOFF = TRNG_RCT_CNT_W'(RCT_CUTOFF);
   localparam logic [TRNG_RCT_CNT_W-1:0] ONE    = TRNG_RCT_CNT_W'(1);

   logic [TRNG_RCT_CNT_W-1:0] run_q;
   logic [TRNG_RCT_CNT_W-1:0] run_d;
   logic                      prev_q;
   logic                      trip;

   always_comb begin
      run_d = run_q;
      if (sample != prev_q) begin
         run_d = ONE;
      end else if (run_q != CUTOFF) begin
         run_d = run_q + ONE;
      end
      trip = sample_valid && (run_d == CUTOFF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q  <= '0;
         prev_q <= 1'b0;
         fail   <= 1'b0;
      end else begin
         if (sample_valid) begin
            prev_q <= sample;
            run_q  <= run_d;
         end
         // A trip on the same edge as a clear takes precedence.
         if (trip) begin
            fail <= 1'b1;
         end else if (clr) begin
            fail  <= 1'b0;
            run_q <= '0;
         end
      end
   end

endmodule

// File: rtl/trng_entropy_packer.sv
// Von Neumann debiaser + repetition-count health test + 32-bit word packer.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : collection enable; low clears debiaser and accumulator
//   raw_bit     : raw entropy sample (already synchronised)
//   raw_valid   : raw_bit valid this cycle
//   out_data    : packed word (first debiased bit in MSB)
//   out_valid   : out_data holds an unconsumed word
//   out_ready   : consumer accepts the word
//   health_fail : sticky repetition-count failure
//   health_clr  : single-cycle clear for health_fail
//   overrun     : one-cycle pulse when a debiased bit is dropped
//   bit_count   : bits currently held in the accumulator, 0..32
module trng_entropy_packer
   import trng_pkg::*;
#(
   parameter int unsigned WORD_W     = TRNG_WORD_W,
   parameter int unsigned RCT_CUTOFF = TRNG_RCT_CUTOFF_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              raw_bit,
   input  logic              raw_valid,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              health_fail,
   input  logic              health_clr,
   output logic              overrun,
   output logic [5:0]        bit_count
);

   localparam logic [5:0] FULL_CNT = 6'(WORD_W);
   localparam logic [5:0] LAST_CNT = 6'(WORD_W - 1);

   vn_state_t         vn_state_q;
   vn_state_t         vn_state_d;
   logic              first_q;
   logic              accept;
   logic              pair_emit;
   logic              pair_bit;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] hold_data;
   logic              hold_valid;
   logic              drain;
   logic              acc_full;
   logic              flush;

   assign accept   = raw_valid && enable && !health_fail;
   assign flush    = !enable || health_fail;
   assign drain    = hold_valid && out_ready;
   assign acc_full = (bit_count == FULL_CNT);

   assign out_data  = hold_data;
   assign out_valid = hold_valid;

   trng_rct_monitor #(
      .RCT_CUTOFF (RCT_CUTOFF)
   ) u_rct (
      .clk          (clk),
      .rst          (rst),
      .sample       (raw_bit),
      .sample_valid (accept),
      .clr          (health_clr),
      .fail         (health_fail)
   );

   // Debiaser: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         vn_state_q <= VN_FIRST;
      end else begin
         vn_state_q <= vn_state_d;
      end
   end

   // Debiaser: next state
   always_comb begin
      vn_state_d = vn_state_q;
      if (flush) begin
         vn_state_d = VN_FIRST;
      end else if (accept) begin
         vn_state_d = (vn_state_q == VN_FIRST) ? VN_SECOND : VN_FIRST;
      end
   end

   // Debiaser: outputs (10 -> 1, 01 -> 0, equal pairs discarded)
   always_comb begin
      pair_emit = accept && (vn_state_q == VN_SECOND) && (first_q != raw_bit);
      pair_bit  = first_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q <= 1'b0;
      end else if (accept && (vn_state_q == VN_FIRST)) begin
         first_q <= raw_bit;
      end
   end

   // Accumulator and holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         bit_count  <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (drain) begin
            hold_valid <= 1'b0;
         end
         if (flush) begin
            acc       <= '0;
            bit_count <= '0;
         end else if (acc_full) begin
            if (drain) begin
               // Stalled word moves into the emptying holding register; a bit
               // arriving on that edge starts the next word instead of being lost.
               hold_data  <= acc;
               hold_valid <= 1'b1;
               if (pair_emit) begin
                  acc       <= {{(WORD_W-1){1'b0}}, pair_bit};
                  bit_count <= 6'd1;
               end else begin
                  acc       <= '0;
                  bit_count <= '0;
               end
            end else if (pair_emit) begin
               overrun <= 1'b1;
            end
         end else if (pair_emit) begin
            if ((bit_count == LAST_CNT) && (!hold_valid || drain)) begin
               hold_data  <= {acc[WORD_W-2:0], pair_bit};
               hold_valid <= 1'b1;
               acc        <= '0;
               bit_count  <= '0;
            end else begin
               acc       <= {acc[WORD_W-2:0], pair_bit};
               bit_count <= bit_count + 6'd1;
            end
         end
      end
   end

endmodule
